// File: rtl/bit_balancer_pkg.sv
// Shared constants and helpers for the bit balancer pipeline.
package bit_balancer_pkg;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

    // Bits needed to hold a count of 0..w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // min(a + b, max) evaluated without wrap-around.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

    // True when a + b would exceed max.
    function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s > {1'b0, max};
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count built as a balanced binary adder tree.
module popcount_tree #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]           bits_i,
    output logic [$clog2(W+1)-1:0] count_o
);

    localparam int unsigned OW = $clog2(W + 1);

    if (W == 1) begin : g_leaf
        assign count_o = bits_i;
    end else begin : g_node
        localparam int unsigned LW  = (W + 1) / 2;
        localparam int unsigned HW  = W / 2;
        localparam int unsigned LOW = $clog2(LW + 1);
        localparam int unsigned HOW = $clog2(HW + 1);

        logic [LOW-1:0] lo_cnt;
        logic [HOW-1:0] hi_cnt;

        popcount_tree #(.W(LW)) u_lo (
            .bits_i  (bits_i[LW-1:0]),
            .count_o (lo_cnt)
        );

        popcount_tree #(.W(HW)) u_hi (
            .bits_i  (bits_i[W-1:LW]),
            .count_o (hi_cnt)
        );

        assign count_o = OW'(lo_cnt) + OW'(hi_cnt);
    end

endmodule

// File: rtl/bit_balancer_pipe.sv
// Two-stage ones/zeros counter with per-word disparity and a saturating per-frame total.
module bit_balancer_pipe
    import bit_balancer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_last,
    input  logic                    mode,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        out_count,
    output logic signed [CNT_W:0]   out_disparity,
    output logic                    out_balanced,
    output logic                    frame_valid,
    output logic [ACC_W-1:0]        frame_total,
    output logic [ACC_W-1:0]        frame_words,
    output logic                    frame_sat
);

    localparam int unsigned LO_W  = (WIDTH + 1) / 2;
    localparam int unsigned HI_W  = WIDTH / 2;
    localparam int unsigned LO_CW = cnt_width(LO_W);
    localparam int unsigned HI_CW = cnt_width(HI_W);
    localparam int unsigned DSP_W = CNT_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [LO_CW-1:0] lo_cnt, s1_lo_q;
    logic [HI_CW-1:0] hi_cnt, s1_hi_q;
    logic             s1_valid_q, s1_last_q, s1_mode_q;

    logic [CNT_W-1:0] ones, zeros, count_d, count_q;
    logic [DSP_W-1:0] disp_d, disp_q;
    logic             bal_d, bal_q;
    logic             valid_q, last_q;

    logic [ACC_W-1:0] acc_q, wcnt_q, acc_sum, wcnt_inc;
    logic             sat_q, acc_ovf;
    logic             ftot_valid_q, fsat_q;
    logic [ACC_W-1:0] ftot_q, fwords_q;

    popcount_tree #(.W(LO_W)) u_pop_lo (
        .bits_i  (in_data[LO_W-1:0]),
        .count_o (lo_cnt)
    );

    popcount_tree #(.W(HI_W)) u_pop_hi (
        .bits_i  (in_data[WIDTH-1:LO_W]),
        .count_o (hi_cnt)
    );

    // Stage 1: register half counts and the word qualifiers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= MODE_ONES;
            s1_lo_q    <= '0;
            s1_hi_q    <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_last_q  <= in_valid & in_last;
            s1_mode_q  <= mode;
            s1_lo_q    <= lo_cnt;
            s1_hi_q    <= hi_cnt;
        end
    end

    // Stage 2 combine: total ones, selected count, disparity and balance.
    always_comb begin
        ones    = CNT_W'(s1_lo_q) + CNT_W'(s1_hi_q);
        zeros   = CNT_W'(WIDTH) - ones;
        count_d = (s1_mode_q == MODE_ZEROS) ? zeros : ones;
        disp_d  = {ones, 1'b0} - DSP_W'(WIDTH);
        bal_d   = ({ones, 1'b0} == DSP_W'(WIDTH));
    end

    // Stage 2 registers; data only loads on valid words so it holds across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
            disp_q  <= '0;
            bal_q   <= 1'b0;
        end else begin
            valid_q <= s1_valid_q;
            last_q  <= s1_last_q;
            if (s1_valid_q) begin
                count_q <= count_d;
                disp_q  <= disp_d;
                bal_q   <= bal_d;
            end
        end
    end

    // Saturating next values for the running frame total and word count.
    always_comb begin
        acc_sum  = ACC_W'(sat_add(32'(acc_q), 32'(count_q), 32'(ACC_MAX)));
        acc_ovf  = add_ovf(32'(acc_q), 32'(count_q), 32'(ACC_MAX));
        wcnt_inc = ACC_W'(sat_add(32'(wcnt_q), 32'd1, 32'(ACC_MAX)));
    end

    // Running accumulator; a closing word restarts it for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            wcnt_q <= '0;
            sat_q  <= 1'b0;
        end else if (valid_q) begin
            if (last_q) begin
                acc_q  <= '0;
                wcnt_q <= '0;
                sat_q  <= 1'b0;
            end else begin
                acc_q  <= acc_sum;
                wcnt_q <= wcnt_inc;
                sat_q  <= sat_q | acc_ovf;
            end
        end
    end

    // Frame results: one-cycle pulse, values held until the next frame closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ftot_valid_q <= 1'b0;
            ftot_q       <= '0;
            fwords_q     <= '0;
            fsat_q       <= 1'b0;
        end else begin
            ftot_valid_q <= valid_q & last_q;
            if (valid_q && last_q) begin
                ftot_q   <= acc_sum;
                fwords_q <= wcnt_inc;
                fsat_q   <= sat_q | acc_ovf;
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_count     = count_q;
    assign out_disparity = $signed(disp_q);
    assign out_balanced  = bal_q;
    assign frame_valid   = ftot_valid_q;
    assign frame_total   = ftot_q;
    assign frame_words   = fwords_q;
    assign frame_sat     = fsat_q;

endmodule

// File: tb/tb_bit_balancer_pipe.sv
// Scoreboard bench: three configurations (8/16, 8/4, 7/16) driven with the same word stream.
module tb_bit_balancer_pipe;

    typedef struct {
        int cnt;
        int dsp;
        bit bal;
        int cyc;
    } word_exp_t;

    typedef struct {
        int total;
        int words;
        bit sat;
        int cyc;
    } frame_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_last, mode;
    logic [7:0] in_data;

    logic              a_ov, a_bal, a_fv, a_fs;
    logic [3:0]        a_cnt;
    logic signed [4:0] a_dsp;
    logic [15:0]       a_ft, a_fw;

    logic              b_ov, b_bal, b_fv, b_fs;
    logic [3:0]        b_cnt;
    logic signed [4:0] b_dsp;
    logic [3:0]        b_ft, b_fw;

    logic              c_ov, c_bal, c_fv, c_fs;
    logic [2:0]        c_cnt;
    logic signed [3:0] c_dsp;
    logic [15:0]       c_ft, c_fw;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    int wid [3] = '{8, 8, 7};
    int accw[3] = '{16, 4, 16};
    int m_acc[3], m_wcnt[3];
    bit m_sat[3];
    int l_cnt[3], l_dsp[3], l_ft[3], l_fw[3];
    bit l_bal[3], l_fs[3];

    word_exp_t  wq[3][$];
    frame_exp_t fq[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    bit_balancer_pipe #(.WIDTH(8), .ACC_W(16)) u_a (
        .clk (clk), .reset (reset), .in_valid (in_valid), .in_data (in_data),
        .in_last (in_last), .mode (mode), .out_valid (a_ov), .out_count (a_cnt),
        .out_disparity (a_dsp), .out_balanced (a_bal), .frame_valid (a_fv),
        .frame_total (a_ft), .frame_words (a_fw), .frame_sat (a_fs)
    );

    bit_balancer_pipe #(.WIDTH(8), .ACC_W(4)) u_b (
        .clk (clk), .reset (reset), .in_valid (in_valid), .in_data (in_data),
        .in_last (in_last), .mode (mode), .out_valid (b_ov), .out_count (b_cnt),
        .out_disparity (b_dsp), .out_balanced (b_bal), .frame_valid (b_fv),
        .frame_total (b_ft), .frame_words (b_fw), .frame_sat (b_fs)
    );

    bit_balancer_pipe #(.WIDTH(7), .ACC_W(16)) u_c (
        .clk (clk), .reset (reset), .in_valid (in_valid), .in_data (in_data[6:0]),
        .in_last (in_last), .mode (mode), .out_valid (c_ov), .out_count (c_cnt),
        .out_disparity (c_dsp), .out_balanced (c_bal), .frame_valid (c_fv),
        .frame_total (c_ft), .frame_words (c_fw), .frame_sat (c_fs)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Reference model: one expected word per instance, plus a frame record on last.
    task automatic push_word(input logic [7:0] d, input bit last, input bit m);
        for (int i = 0; i < 3; i++) begin
            word_exp_t  we;
            frame_exp_t fe;
            int ones, maxv, sum;
            logic [7:0] mask;
            mask = 8'((1 << wid[i]) - 1);
            ones = $countones(d & mask);
            maxv = (1 << accw[i]) - 1;
            we.cnt = m ? (wid[i] - ones) : ones;
            we.dsp = 2 * ones - wid[i];
            we.bal = (2 * ones == wid[i]);
            we.cyc = cycle + 2;
            wq[i].push_back(we);
            sum = m_acc[i] + we.cnt;
            if (sum > maxv) begin
                sum = maxv;
                m_sat[i] = 1'b1;
            end
            m_acc[i]  = sum;
            m_wcnt[i] = (m_wcnt[i] + 1 > maxv) ? maxv : m_wcnt[i] + 1;
            if (last) begin
                fe.total = m_acc[i];
                fe.words = m_wcnt[i];
                fe.sat   = m_sat[i];
                fe.cyc   = cycle + 3;
                fq[i].push_back(fe);
                m_acc[i]  = 0;
                m_wcnt[i] = 0;
                m_sat[i]  = 1'b0;
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            wq[i].delete();
            fq[i].delete();
            m_acc[i] = 0; m_wcnt[i] = 0; m_sat[i] = 1'b0;
            l_cnt[i] = 0; l_dsp[i] = 0; l_bal[i] = 1'b0;
            l_ft[i] = 0; l_fw[i] = 0; l_fs[i] = 1'b0;
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit last, input bit m);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        in_last  = last;
        mode     = m;
        if (v) push_word(d, last, m);
    endtask

    task automatic mon(input int i, input bit ov, input int c, input int dsp, input bit bal,
                       input bit fv, input int ft, input int fw, input bit fs);
        string p;
        p = $sformatf("u%0d", i);
        if (ov) begin
            if (wq[i].size() == 0) begin
                check_eq({p, "_unexpected_out_valid"}, 1, 0);
            end else begin
                word_exp_t we;
                we = wq[i].pop_front();
                check_eq({p, "_out_cycle"}, cycle, we.cyc);
                check_eq({p, "_out_count"}, c, we.cnt);
                check_eq({p, "_out_disparity"}, dsp, we.dsp);
                check_eq({p, "_out_balanced"}, int'(bal), int'(we.bal));
                l_cnt[i] = we.cnt; l_dsp[i] = we.dsp; l_bal[i] = we.bal;
            end
        end else begin
            check_eq({p, "_hold_count"}, c, l_cnt[i]);
            check_eq({p, "_hold_disparity"}, dsp, l_dsp[i]);
        end
        if (fv) begin
            if (fq[i].size() == 0) begin
                check_eq({p, "_unexpected_frame_valid"}, 1, 0);
            end else begin
                frame_exp_t fe;
                fe = fq[i].pop_front();
                check_eq({p, "_frame_cycle"}, cycle, fe.cyc);
                check_eq({p, "_frame_total"}, ft, fe.total);
                check_eq({p, "_frame_words"}, fw, fe.words);
                check_eq({p, "_frame_sat"}, int'(fs), int'(fe.sat));
                l_ft[i] = fe.total; l_fw[i] = fe.words; l_fs[i] = fe.sat;
            end
        end else begin
            check_eq({p, "_hold_frame_total"}, ft, l_ft[i]);
            check_eq({p, "_hold_frame_words"}, fw, l_fw[i]);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, a_ov, int'(a_cnt), int'(a_dsp), a_bal, a_fv, int'(a_ft), int'(a_fw), a_fs);
            mon(1, b_ov, int'(b_cnt), int'(b_dsp), b_bal, b_fv, int'(b_ft), int'(b_fw), b_fs);
            mon(2, c_ov, int'(c_cnt), int'(c_dsp), c_bal, c_fv, int'(c_ft), int'(c_fw), c_fs);
        end
    end

    task automatic zero_chk(input int i, input bit ov, input int c, input int dsp, input bit bal,
                            input bit fv, input int ft, input int fw, input bit fs);
        string p;
        p = $sformatf("u%0d_rst", i);
        check_eq({p, "_out_valid"}, int'(ov), 0);
        check_eq({p, "_out_count"}, c, 0);
        check_eq({p, "_out_disparity"}, dsp, 0);
        check_eq({p, "_out_balanced"}, int'(bal), 0);
        check_eq({p, "_frame_valid"}, int'(fv), 0);
        check_eq({p, "_frame_total"}, ft, 0);
        check_eq({p, "_frame_words"}, fw, 0);
        check_eq({p, "_frame_sat"}, int'(fs), 0);
    endtask

    // Assert reset after the next edge, check outputs once it has taken effect, then release.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear_model();
        @(posedge clk);
        @(negedge clk);
        zero_chk(0, a_ov, int'(a_cnt), int'(a_dsp), a_bal, a_fv, int'(a_ft), int'(a_fw), a_fs);
        zero_chk(1, b_ov, int'(b_cnt), int'(b_dsp), b_bal, b_fv, int'(b_ft), int'(b_fw), b_fs);
        zero_chk(2, c_ov, int'(c_cnt), int'(c_dsp), c_bal, c_fv, int'(c_ft), int'(c_fw), c_fs);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        mode     = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        apply_reset();

        // Back-to-back frame of four words, mode ones.
        drive(1, 8'hAB, 0, 0);
        drive(1, 8'hF0, 0, 0);
        drive(1, 8'h00, 0, 0);
        drive(1, 8'hFF, 1, 0);
        // Mode switches inside a frame.
        drive(1, 8'h00, 0, 1);
        drive(1, 8'h0F, 1, 0);
        drive(0, 8'h00, 0, 0);
        // Saturating frame followed immediately by a single-word frame.
        drive(1, 8'hFF, 0, 0);
        drive(1, 8'hFF, 0, 0);
        drive(1, 8'hFF, 1, 0);
        drive(1, 8'h01, 1, 0);
        // Frame with input bubbles.
        drive(1, 8'h03, 0, 0);
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        drive(1, 8'h07, 1, 0);
        drive(0, 8'h00, 0, 0);
        repeat (4) @(posedge clk);
        // Unfinished frame cut by reset, then a clean single-word frame.
        drive(1, 8'h0F, 0, 0);
        drive(1, 8'h33, 0, 1);
        apply_reset();
        drive(1, 8'h01, 1, 0);
        drive(0, 8'h00, 0, 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("u%0d_word_queue_drained", i), wq[i].size(), 0);
            check_eq($sformatf("u%0d_frame_queue_drained", i), fq[i].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
